// File: rtl/i2s_tx_sequencer.sv
// I2S transmit sequencer: divides clk into BCLK/LRCK, strobes load/shift for a
// downstream 32-bit MSB-first shift register and double-buffers one L/R pair.
module i2s_tx_sequencer #(
  parameter int unsigned HALF_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_l,
  input  logic [15:0] in_r,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        bclk,
  output logic        lrck,
  output logic        load,
  output logic        shift,
  output logic [31:0] word,
  output logic        frame_start,
  output logic        underrun
);

  localparam logic [7:0] DIV_LAST = 8'(HALF_DIV - 1);

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_e;

  buf_state_e  buf_state_q, buf_state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        bclk_q, bclk_d;
  logic        lrck_q, lrck_d;
  logic        load_q, load_d;
  logic        shift_q, shift_d;
  logic        frame_start_q, frame_start_d;
  logic        underrun_q, underrun_d;
  logic [31:0] word_q, word_d;
  logic [15:0] buf_l_q, buf_l_d;
  logic [15:0] buf_r_q, buf_r_d;
  logic [15:0] active_r_q, active_r_d;

  logic div_wrap, fall_tick, load_tick, left_load, accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_state_q   <= BUF_EMPTY;
      div_cnt_q     <= '0;
      bit_cnt_q     <= '1;
      bclk_q        <= 1'b0;
      lrck_q        <= 1'b1;
      load_q        <= 1'b0;
      shift_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
      word_q        <= '0;
      buf_l_q       <= '0;
      buf_r_q       <= '0;
      active_r_q    <= '0;
    end else begin
      buf_state_q   <= buf_state_d;
      div_cnt_q     <= div_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      bclk_q        <= bclk_d;
      lrck_q        <= lrck_d;
      load_q        <= load_d;
      shift_q       <= shift_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
      word_q        <= word_d;
      buf_l_q       <= buf_l_d;
      buf_r_q       <= buf_r_d;
      active_r_q    <= active_r_d;
    end
  end

  always_comb begin
    div_wrap  = (div_cnt_q == DIV_LAST);
    fall_tick = div_wrap && bclk_q;
    load_tick = fall_tick && (bit_cnt_q == 5'd0);
    left_load = load_tick && !lrck_q;
    accept    = in_valid && (buf_state_q == BUF_EMPTY);

    div_cnt_d     = div_wrap ? '0 : div_cnt_q + 8'd1;
    bclk_d        = bclk_q ^ div_wrap;
    bit_cnt_d     = fall_tick ? bit_cnt_q + 5'd1 : bit_cnt_q;
    lrck_d        = lrck_q ^ (fall_tick && (bit_cnt_q == 5'd31));
    load_d        = load_tick;
    shift_d       = fall_tick && !load_tick;
    frame_start_d = left_load;
    underrun_d    = left_load && (buf_state_q == BUF_EMPTY);

    buf_state_d = buf_state_q;
    word_d      = word_q;
    buf_l_d     = buf_l_q;
    buf_r_d     = buf_r_q;
    active_r_d  = active_r_q;

    if (left_load) begin
      if (buf_state_q == BUF_FULL) begin
        word_d      = {buf_l_q, 16'h0000};
        active_r_d  = buf_r_q;
        buf_state_d = BUF_EMPTY;
      end else begin
        word_d     = '0;
        active_r_d = '0;
      end
    end else if (load_tick) begin
      word_d = {active_r_q, 16'h0000};
    end

    // Acceptance is only possible when empty, so it never collides with the
    // full-buffer drain above; an acceptance during an underrun load lands after it.
    if (accept) begin
      buf_l_d     = in_l;
      buf_r_d     = in_r;
      buf_state_d = BUF_FULL;
    end
  end

  assign in_ready    = (buf_state_q == BUF_EMPTY);
  assign bclk        = bclk_q;
  assign lrck        = lrck_q;
  assign load        = load_q;
  assign shift       = shift_q;
  assign word        = word_q;
  assign frame_start = frame_start_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Directed bench for i2s_tx_sequencer (HALF_DIV = 4) with a downstream shift
// register model that reassembles the serial stream on BCLK rising edges.
module tb_i2s_tx_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] in_l = '0;
  logic [15:0] in_r = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, bclk, lrck, load, shift, frame_start, underrun;
  logic [31:0] word;

  int unsigned total = 0;
  int unsigned bad = 0;
  int          cyc = 0;

  i2s_tx_sequencer #(.HALF_DIV(4)) dut (
    .clk(clk), .reset(reset), .in_l(in_l), .in_r(in_r), .in_valid(in_valid),
    .in_ready(in_ready), .bclk(bclk), .lrck(lrck), .load(load), .shift(shift),
    .word(word), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // cyc equals the number of clock edges since the last reset edge
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  logic [31:0] sr, sacc;
  int unsigned sbits, rises, first_rise;
  logic        sch, pbclk, plrck;
  logic [15:0] ser_l[$], ser_r[$], ser_lo[$];
  int unsigned ser_dly[$];

  always @(negedge clk) begin
    if (reset) begin
      sr = '0; sacc = '0; sbits = 32; rises = 0; first_rise = 0;
      sch = 1'b0; pbclk = 1'b0; plrck = 1'b1;
      ser_l.delete(); ser_r.delete(); ser_lo.delete(); ser_dly.delete();
    end else begin
      if (lrck !== plrck) rises = 0;
      if (bclk && !pbclk) begin
        rises++;
        if (sbits < 32) begin
          if (sbits == 0) first_rise = rises;
          sacc = {sacc[30:0], sr[31]};
          sbits++;
          if (sbits == 32) begin
            if (sch) ser_r.push_back(sacc[31:16]);
            else ser_l.push_back(sacc[31:16]);
            ser_lo.push_back(sacc[15:0]);
            ser_dly.push_back(first_rise);
          end
        end
      end
      if (load) begin
        sr = word; sbits = 0; sch = lrck;
      end else if (shift) begin
        sr = {sr[30:0], 1'b0};
      end
      pbclk = bclk; plrck = lrck;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_load(input string tag);
    int unsigned n = 0;
    @(negedge clk);
    while (load !== 1'b1 && n < 700) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (load !== 1'b1) begin bad++; $display("FAIL %s_load_timeout: load=%b expected=1", tag, load); end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b1; in_l = 16'hDEAD; in_r = 16'hBEEF;
    repeat (5) @(negedge clk);
    total += 8;
    if (bclk !== 1'b0)        begin bad++; $display("FAIL rst_bclk: got=%b exp=0", bclk); end
    if (lrck !== 1'b1)        begin bad++; $display("FAIL rst_lrck: got=%b exp=1", lrck); end
    if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_in_ready: got=%b exp=1", in_ready); end
    if (load !== 1'b0)        begin bad++; $display("FAIL rst_load: got=%b exp=0", load); end
    if (shift !== 1'b0)       begin bad++; $display("FAIL rst_shift: got=%b exp=0", shift); end
    if (word !== 32'h0)       begin bad++; $display("FAIL rst_word: got=%h exp=00000000", word); end
    if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_frame_start: got=%b exp=0", frame_start); end
    if (underrun !== 1'b0)    begin bad++; $display("FAIL rst_underrun: got=%b exp=0", underrun); end
    in_valid = 1'b0;
  endtask

  task automatic test_clock();
    int unsigned n_ld = 0, n_sh = 0, n_fs = 0, n_ur = 0, n_rise = 0, both = 0, wide = 0, per_err = 0;
    int first_fall = -1, second_fall = -1, last_rise = -1;
    int ld_cyc[$];
    logic pb = 1'b0, pl = 1'b1, plo = 1'b0, psh = 1'b0;
    do_reset();
    for (int k = 0; k <= 530; k++) begin
      @(negedge clk);
      if (lrck === 1'b0 && pl === 1'b1) begin
        if (first_fall < 0) first_fall = k; else if (second_fall < 0) second_fall = k;
      end
      if (load) ld_cyc.push_back(k);
      if (bclk && !pb) begin
        if (last_rise >= 0 && k - last_rise != 8) per_err++;
        last_rise = k;
      end
      if (k >= 16 && k < 528) begin
        if (load) n_ld++;
        if (shift) n_sh++;
        if (frame_start) n_fs++;
        if (underrun) n_ur++;
        if (bclk && !pb) n_rise++;
      end
      if (load && shift) both++;
      if ((load && plo) || (shift && psh)) wide++;
      pb = bclk; pl = lrck; plo = load; psh = shift;
    end
    total += 11;
    if (first_fall != 8)    begin bad++; $display("FAIL clk_first_lrck_fall: got=%0d exp=8", first_fall); end
    if (second_fall - first_fall != 512) begin bad++; $display("FAIL clk_lrck_period: got=%0d exp=512", second_fall - first_fall); end
    if (ld_cyc.size() < 3 || ld_cyc[0] != 16 || ld_cyc[1] != 272 || ld_cyc[2] != 528)
      begin bad++; $display("FAIL clk_load_cycles: got=%p exp=16,272,528", ld_cyc); end
    if (n_ld != 2)    begin bad++; $display("FAIL clk_loads: got=%0d exp=2", n_ld); end
    if (n_sh != 62)   begin bad++; $display("FAIL clk_shifts: got=%0d exp=62", n_sh); end
    if (n_fs != 1)    begin bad++; $display("FAIL clk_frame_start: got=%0d exp=1", n_fs); end
    if (n_ur != 1)    begin bad++; $display("FAIL clk_underrun: got=%0d exp=1", n_ur); end
    if (n_rise != 64) begin bad++; $display("FAIL clk_bclk_rises: got=%0d exp=64", n_rise); end
    if (per_err != 0) begin bad++; $display("FAIL clk_bclk_period: bad_periods=%0d exp=0", per_err); end
    if (both != 0)    begin bad++; $display("FAIL clk_load_shift_overlap: got=%0d exp=0", both); end
    if (wide != 0)    begin bad++; $display("FAIL clk_strobe_width: got=%0d exp=0", wide); end
  endtask

  task automatic test_single_pair();
    do_reset();
    in_l = 16'h8001; in_r = 16'h7FFE; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_load("single_left");
    total += 5;
    if (cyc != 16)              begin bad++; $display("FAIL single_left_cycle: got=%0d exp=16", cyc); end
    if (lrck !== 1'b0)          begin bad++; $display("FAIL single_left_lrck: got=%b exp=0", lrck); end
    if (word !== 32'h80010000)  begin bad++; $display("FAIL single_left_word: got=%h exp=80010000", word); end
    if (underrun !== 1'b0)      begin bad++; $display("FAIL single_underrun: got=%b exp=0", underrun); end
    if (frame_start !== 1'b1)   begin bad++; $display("FAIL single_frame_start: got=%b exp=1", frame_start); end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1)      begin bad++; $display("FAIL single_in_ready_after: got=%b exp=1", in_ready); end
    wait_load("single_right");
    total += 2;
    if (lrck !== 1'b1)          begin bad++; $display("FAIL single_right_lrck: got=%b exp=1", lrck); end
    if (word !== 32'h7FFE0000)  begin bad++; $display("FAIL single_right_word: got=%h exp=7ffe0000", word); end
  endtask

  task automatic test_back_to_back();
    int unsigned idx = 0, nl = 0, nr = 0, acc_in_frame = 0, ready_err = 0, acc_err = 0;
    logic a;
    logic [31:0] exp_w;
    do_reset();
    in_l = 16'h1000; in_r = 16'h2000; in_valid = 1'b1;
    for (int k = 0; k <= 2064; k++) begin
      @(negedge clk);
      a = in_valid && in_ready;
      if (in_ready && k > 0 && !(load && !lrck)) ready_err++;
      if (load && !lrck) begin
        exp_w = {16'(16'h1000 + nl), 16'h0000};
        total++;
        if (word !== exp_w) begin bad++; $display("FAIL b2b_left_word[%0d]: got=%h exp=%h", nl, word, exp_w); end
        if (nl > 0 && acc_in_frame != 1) acc_err++;
        acc_in_frame = 0;
        nl++;
      end else if (load) begin
        exp_w = {16'(16'h2000 + nr), 16'h0000};
        total++;
        if (word !== exp_w) begin bad++; $display("FAIL b2b_right_word[%0d]: got=%h exp=%h", nr, word, exp_w); end
        nr++;
      end
      if (a) acc_in_frame++;
      @(posedge clk); #1;
      if (a) begin
        idx++;
        in_l = 16'(16'h1000 + idx);
        in_r = 16'(16'h2000 + idx);
      end
    end
    in_valid = 1'b0;
    total += 4;
    if (nl != 5)        begin bad++; $display("FAIL b2b_left_loads: got=%0d exp=5", nl); end
    if (nr != 4)        begin bad++; $display("FAIL b2b_right_loads: got=%0d exp=4", nr); end
    if (acc_err != 0)   begin bad++; $display("FAIL b2b_accepts_per_frame: bad_frames=%0d exp=0", acc_err); end
    if (ready_err != 0) begin bad++; $display("FAIL b2b_ready_low: high_cycles=%0d exp=0", ready_err); end
  endtask

  task automatic test_underrun();
    do_reset();
    wait_load("ur_left0");
    total += 4;
    if (lrck !== 1'b0)        begin bad++; $display("FAIL ur_left0_lrck: got=%b exp=0", lrck); end
    if (underrun !== 1'b1)    begin bad++; $display("FAIL ur_left0_underrun: got=%b exp=1", underrun); end
    if (frame_start !== 1'b1) begin bad++; $display("FAIL ur_left0_frame_start: got=%b exp=1", frame_start); end
    if (word !== 32'h0)       begin bad++; $display("FAIL ur_left0_word: got=%h exp=00000000", word); end
    @(posedge clk); #1;
    in_l = 16'hA5A5; in_r = 16'h5A5A; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_load("ur_right0");
    total += 2;
    if (word !== 32'h0)       begin bad++; $display("FAIL ur_right0_word: got=%h exp=00000000", word); end
    if (underrun !== 1'b0)    begin bad++; $display("FAIL ur_right0_underrun: got=%b exp=0", underrun); end
    wait_load("ur_left1");
    total += 2;
    if (underrun !== 1'b0)      begin bad++; $display("FAIL ur_left1_underrun: got=%b exp=0", underrun); end
    if (word !== 32'hA5A50000)  begin bad++; $display("FAIL ur_left1_word: got=%h exp=a5a50000", word); end
    wait_load("ur_right1");
    total++;
    if (word !== 32'h5A5A0000)  begin bad++; $display("FAIL ur_right1_word: got=%h exp=5a5a0000", word); end
  endtask

  task automatic test_serial();
    do_reset();
    in_l = 16'hA55A; in_r = 16'h3CC3; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_load("ser_left");
    @(posedge clk); #1;
    in_l = 16'hFFFF; in_r = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    while (cyc < 1045) begin @(posedge clk); #1; end
    total += 4;
    if (ser_l.size() != 2 || ser_l[0] !== 16'hA55A || ser_l[1] !== 16'hFFFF)
      begin bad++; $display("FAIL ser_left: got=%p exp=a55a,ffff", ser_l); end
    if (ser_r.size() != 2 || ser_r[0] !== 16'h3CC3 || ser_r[1] !== 16'h0001)
      begin bad++; $display("FAIL ser_right: got=%p exp=3cc3,0001", ser_r); end
    if (ser_dly.size() != 4 || ser_dly[0] != 2 || ser_dly[1] != 2 || ser_dly[2] != 2 || ser_dly[3] != 2)
      begin bad++; $display("FAIL ser_msb_delay: got=%p exp=2,2,2,2 bclk rises after lrck", ser_dly); end
    if (ser_lo.size() != 4 || (ser_lo[0] | ser_lo[1] | ser_lo[2] | ser_lo[3]) !== 16'h0)
      begin bad++; $display("FAIL ser_low_half: got=%p exp=zeros", ser_lo); end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    in_l = 16'h1111; in_r = 16'h2222; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_load("mid_left");
    @(posedge clk); #1;
    in_l = 16'h3333; in_r = 16'h4444; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    while (cyc < 403) begin @(posedge clk); #1; end
    total += 2;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_pre_full: in_ready=%b exp=0", in_ready); end
    if (lrck !== 1'b1)     begin bad++; $display("FAIL mid_pre_lrck: got=%b exp=1", lrck); end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    total += 6;
    if (in_ready !== 1'b1)  begin bad++; $display("FAIL mid_rst_in_ready: got=%b exp=1", in_ready); end
    if (lrck !== 1'b1)      begin bad++; $display("FAIL mid_rst_lrck: got=%b exp=1", lrck); end
    if (bclk !== 1'b0)      begin bad++; $display("FAIL mid_rst_bclk: got=%b exp=0", bclk); end
    if (word !== 32'h0)     begin bad++; $display("FAIL mid_rst_word: got=%h exp=00000000", word); end
    if ((load | shift) !== 1'b0) begin bad++; $display("FAIL mid_rst_strobes: load=%b shift=%b exp=0", load, shift); end
    if ((frame_start | underrun) !== 1'b0)
      begin bad++; $display("FAIL mid_rst_pulses: fs=%b ur=%b exp=0", frame_start, underrun); end
    wait_load("mid_post");
    total += 4;
    if (cyc != 16)         begin bad++; $display("FAIL mid_post_cycle: got=%0d exp=16", cyc); end
    if (lrck !== 1'b0)     begin bad++; $display("FAIL mid_post_lrck: got=%b exp=0", lrck); end
    if (underrun !== 1'b1) begin bad++; $display("FAIL mid_post_underrun: got=%b exp=1", underrun); end
    if (word !== 32'h0)    begin bad++; $display("FAIL mid_post_word: got=%h exp=00000000", word); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clock();
    test_single_pair();
    test_back_to_back();
    test_underrun();
    test_serial();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_sequencer.md
I2S_TX_SEQUENCER -- requirements
Module: i2s_tx_sequencer

Interface
REQ-001 The block SHALL have one parameter: HALF_DIV, default 4, meaning clk cycles per BCLK half-period (legal range 2..255).
REQ-002 The block SHALL have the following ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  reset, synchronous, active-high.
- in_l  input  16  left sample, two's complement.
- in_r  input  16  right sample, two's complement.
- in_valid  input  1  sample pair offered.
- in_ready  output  1  holding buffer empty; pair accepted when in_valid and in_ready are both high.
- bclk  output  1  codec bit clock, registered.
- lrck  output  1  DAC LR clock, registered; 0 = left, 1 = right.
- load  output  1  one-cycle load strobe for the downstream 32-bit MSB-first shift register.
- shift  output  1  one-cycle shift strobe for the same register.
- word  output  32  parallel word for the shift register; valid in every cycle where load is 1.
- frame_start  output  1  one-cycle pulse coincident with each left-channel load.
- underrun  output  1  one-cycle pulse coincident with a left load that finds no buffered pair.

Function
REQ-003 div_cnt SHALL count 0..HALF_DIV-1 and wrap to 0; at the terminal count bclk SHALL toggle.
REQ-004 fall_tick SHALL be true in a cycle where div_cnt = HALF_DIV-1 and bclk = 1; bclk is first low in the following cycle.
REQ-005 bit_cnt (5 bits) SHALL increment modulo 32 on each fall_tick.
REQ-006 lrck SHALL toggle on the fall_tick where bit_cnt goes 31->0; one channel spans 32 BCLK periods, one frame spans 64.
REQ-007 On the fall_tick where bit_cnt goes 0->1, load SHALL be 1 in the next cycle and shift SHALL be 0 in that cycle.
REQ-008 On every other fall_tick, shift SHALL be 1 in the next cycle; there SHALL be exactly 31 shifts between consecutive loads.
REQ-009 Consequence of REQ-006..REQ-008: the MSB appears on the second BCLK rising edge after an lrck change, in standard I2S 1-bit-delay format.
REQ-010 load and shift SHALL never be 1 in the same cycle, and each SHALL be high for exactly one clk cycle.
REQ-011 Holding buffer: one L/R pair plus a buf_full flag; in_ready SHALL equal !buf_full (registered).
REQ-012 An accepted pair SHALL be written to the buffer and SHALL set buf_full in the next cycle.
REQ-013 Left load (lrck = 0), buffer full:
- word SHALL equal {buf_l, 16'h0000}.
- active_r SHALL be set to buf_r.
- buf_full SHALL clear.
- frame_start SHALL pulse.
REQ-014 Left load, buffer empty:
- word SHALL equal 32'h0.
- active_r SHALL be set to 16'h0.
- frame_start and underrun SHALL both pulse.
REQ-015 Right load (lrck = 1): word SHALL equal {active_r, 16'h0000}; the buffer is untouched.
REQ-016 An acceptance in the same cycle as a left load SHALL NOT be possible, because buf_full is 1 (REQ-013) or the pair lands after evaluation (REQ-014); a pair accepted at or after the left-load cycle SHALL be played in the next frame.
REQ-017 word SHALL hold its value between loads.
REQ-018 Without an intervening left load, in_ready SHALL stay low however long in_valid is held; no pair SHALL be dropped or overwritten.

Reset
REQ-019 While reset is 1, the block SHALL hold:
- div_cnt = 0, bclk = 0, lrck = 1, bit_cnt = 31.
- buf_full = 0, in_ready = 1.
- load = 0, shift = 0, word = 32'h0.
- frame_start = 0, underrun = 0, active_r = 0.
REQ-020 Reset SHALL take priority over all other events, including mid-frame.
REQ-021 After reset deasserts:
- The first fall_tick (2*HALF_DIV cycles in) SHALL drive lrck to 0.
- The first left load SHALL follow one BCLK period later.
- Any buffered pair SHALL be discarded by reset.

Verification
REQ-022 Clock check: HALF_DIV = 4, idle inputs -> bclk period 8 clk, lrck period 512 clk, 2 loads and 62 shifts per frame, underrun and frame_start pulse once per frame.
REQ-023 Single pair: in_l = 16'h8001 and in_r = 16'h7FFE presented before the first left load -> left load word = 32'h80010000, right load word = 32'h7FFE0000, no underrun, in_ready high again 1 cycle after the left load.
REQ-024 Back-pressure: in_valid held high continuously with incrementing pairs -> exactly one pair accepted per frame, no skipped or duplicated values, in_ready low between acceptance and the next left load.
REQ-025 Underrun: buffer empty at a left load -> underrun pulse, word = 32'h0 for both channels, recovers on the next frame once a pair is supplied.
REQ-026 Reset mid-frame: reset asserted at bit_cnt = 17 of the right channel with buffer full -> all outputs at their REQ-019 values next cycle, in_ready = 1, first post-reset left load reports underrun.
REQ-027 Serial check: downstream 32-bit shift register model connected, serialised on BCLK rising edges -> reconstructed left/right samples equal the inputs with the I2S one-bit delay.
